// File: rtl/trap_request_arbiter.sv
// trap_request_arbiter
//   Collects trap/interrupt events into sticky pending bits, masks them,
//   picks a fixed-priority winner (lowest index) and presents one vectored
//   request at a time to the pipeline monitor over a req/ack handshake.
//   While a handler runs, no new request is raised. There is no nesting.
//
// Ports
//   clk, rst     clock; synchronous active-high reset
//   src_in       raw event lines; a rising edge raises the event
//   mask_wr      write strobe for mask_data -> mask_q
//   core_ready   pipeline can accept a trap
//   irq_ack      monitor took the trap
//   irq_done     handler returned (one-cycle pulse)
//   irq_req      trap request to the monitor
//   irq_id       index of the requesting source
//   irq_vec      handler address for irq_id
//   pending      sticky pending bits
//   mask_q       current enable mask (1 = enabled)
//   busy         handler in service
module trap_request_arbiter #(
  parameter logic [15:0] VEC0     = 16'h0030,
  parameter logic [15:0] VEC1     = 16'h0500,
  parameter logic [15:0] VEC2     = 16'h0090,
  parameter logic [15:0] VEC3     = 16'h0100,
  parameter logic [3:0]  MASK_RST = 4'b1111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  src_in,
  input  logic        mask_wr,
  input  logic [3:0]  mask_data,
  input  logic        core_ready,
  input  logic        irq_ack,
  input  logic        irq_done,
  output logic        irq_req,
  output logic [1:0]  irq_id,
  output logic [15:0] irq_vec,
  output logic [3:0]  pending,
  output logic [3:0]  mask_q,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  src_prev_q;
  logic [3:0]  pend_q, pend_d;
  logic [3:0]  mask_d;
  logic [1:0]  id_q, id_d;
  logic [15:0] vec_q, vec_d;

  logic [3:0]  rise, eligible, clr;
  logic [1:0]  winner;

  function automatic logic [15:0] vec_sel(input logic [1:0] idx);
    case (idx)
      2'd0:    vec_sel = VEC0;
      2'd1:    vec_sel = VEC1;
      2'd2:    vec_sel = VEC2;
      default: vec_sel = VEC3;
    endcase
  endfunction

  always_comb begin
    rise     = src_in & ~src_prev_q;
    eligible = pend_q & mask_q;
    // Scan high to low so the lowest set index wins.
    winner   = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (eligible[i]) winner = 2'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    vec_d   = vec_q;
    clr     = 4'b0000;
    case (state_q)
      IDLE: begin
        if (|eligible && core_ready) begin
          state_d = REQ;
          id_d    = winner;
          vec_d   = vec_sel(winner);
        end
      end
      REQ: begin
        // Ack takes precedence over a same-cycle mask-off of the source.
        if (irq_ack) begin
          clr     = 4'b0001 << id_q;
          state_d = SERVICE;
        end else if (!mask_q[id_q]) begin
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (irq_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A fresh edge on the acked source wins over its clear.
    pend_d = (pend_q & ~clr) | rise;
    mask_d = mask_wr ? mask_data : mask_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      // All-ones so lines already high at reset release do not fire.
      src_prev_q <= 4'b1111;
      pend_q     <= 4'b0000;
      mask_q     <= MASK_RST;
      id_q       <= 2'd0;
      vec_q      <= 16'h0000;
    end else begin
      state_q    <= state_d;
      src_prev_q <= src_in;
      pend_q     <= pend_d;
      mask_q     <= mask_d;
      id_q       <= id_d;
      vec_q      <= vec_d;
    end
  end

  assign irq_req = (state_q == REQ);
  assign busy    = (state_q == SERVICE);
  assign irq_id  = id_q;
  assign irq_vec = vec_q;
  assign pending = pend_q;

endmodule
